// File: rtl/fifo2_256_reader_pkg.sv
// Shared definitions for the two-half frame readers.
// - log2: ceiling log2, used to size index and column counters
// - DEF_*: default element width, frame geometry and derived frame/half sizes
// - state_e: reader FSM state encoding
package fifo2_256_reader_pkg;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_WIDTH      = 256;
  localparam int unsigned DEF_HEIGHT     = 256;
  localparam int unsigned DEF_SIZE       = DEF_WIDTH * DEF_HEIGHT;
  localparam int unsigned DEF_HALF       = DEF_SIZE / 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/half_buf_select.sv
// Picks one element out of a frame split across two half-frame flat buses.
// Ports:
// - idx   in   IW                 element index, 0..2*HALF-1
// - all_1 in   HALF*DATA_WIDTH    elements 0..HALF-1
// - all_2 in   HALF*DATA_WIDTH    elements HALF..2*HALF-1
// - elem  out  DATA_WIDTH         selected element
module half_buf_select
  import fifo2_256_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned HALF       = 8,
  parameter int unsigned IW         = 5
) (
  input  logic [IW-1:0]              idx,
  input  logic [HALF*DATA_WIDTH-1:0] all_1,
  input  logic [HALF*DATA_WIDTH-1:0] all_2,
  output logic [DATA_WIDTH-1:0]      elem
);

  localparam int unsigned    BW      = (log2(HALF * DATA_WIDTH) > 0) ?
                                       log2(HALF * DATA_WIDTH) : 1;
  localparam logic [IW-1:0]  HalfIdx = IW'(HALF);

  logic          upper;
  logic [IW-1:0] off;
  logic [BW-1:0] base;

  always_comb begin
    upper = (idx >= HalfIdx);
    // Indices in the upper half are rebased so all_2 slice 0 is element HALF.
    off   = upper ? (idx - HalfIdx) : idx;
    base  = BW'(off * DATA_WIDTH);
    elem  = upper ? all_2[base +: DATA_WIDTH] : all_1[base +: DATA_WIDTH];
  end

endmodule

// File: rtl/fifo2_256_reader.sv
// Streams a full frame held on two half-frame buses out as one element per beat with a
// valid/ready handshake. Source buses must stay stable from start until done.
// Ports:
// - clk, reset    clock; asynchronous active-high reset
// - start         begin a frame (IDLE only); clear: synchronous abort to IDLE
// - all_1, all_2  elements 0..HALF-1 and HALF..SIZE-1
// - data_out      registered current element; valid/ready handshake
// - row_end       beat is last column of a row; last: beat is element SIZE-1
// - busy          not idle; done: one-cycle pulse after final beat is accepted
module fifo2_256_reader
  import fifo2_256_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       clear,
  input  logic [(WIDTH*HEIGHT/2)*DATA_WIDTH-1:0]     all_1,
  input  logic [(WIDTH*HEIGHT/2)*DATA_WIDTH-1:0]     all_2,
  output logic [DATA_WIDTH-1:0]                      data_out,
  output logic                                       valid,
  input  logic                                       ready,
  output logic                                       row_end,
  output logic                                       last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned   SIZE    = WIDTH * HEIGHT;
  localparam int unsigned   HALF    = SIZE / 2;
  localparam int unsigned   IW      = log2(SIZE) + 1;
  localparam int unsigned   CW      = (log2(WIDTH) > 0) ? log2(WIDTH) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(SIZE - 1);
  localparam logic [CW-1:0] LastCol = CW'(WIDTH - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           col_q, col_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [IW-1:0]           sel_idx;
  logic [DATA_WIDTH-1:0]   sel_elem;
  logic                    handshake;

  // Element that would be loaded on this edge: 0 when starting, otherwise the next index.
  // Clamped on the final beat so the selector never sees an out-of-frame index.
  always_comb begin
    if (state_q == StIdle) begin
      sel_idx = '0;
    end else if (idx_q == LastIdx) begin
      sel_idx = idx_q;
    end else begin
      sel_idx = idx_q + 1'b1;
    end
  end

  half_buf_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .HALF       (HALF),
    .IW         (IW)
  ) u_sel (
    .idx   (sel_idx),
    .all_1 (all_1),
    .all_2 (all_2),
    .elem  (sel_elem)
  );

  assign handshake = valid_q & ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      state_d = StIdle;
      valid_d = 1'b0;
      idx_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_d   = '0;
            col_d   = '0;
            data_d  = sel_elem;
            valid_d = 1'b1;
            state_d = StStream;
          end
        end
        StStream: begin
          if (handshake) begin
            if (idx_q == LastIdx) begin
              valid_d = 1'b0;
              state_d = StDone;
            end else begin
              idx_d  = idx_q + 1'b1;
              data_d = sel_elem;
              col_d  = (col_q == LastCol) ? '0 : col_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign row_end  = valid_q & (col_q == LastCol);
  assign last     = valid_q & (idx_q == LastIdx);
  assign busy     = (state_q != StIdle);
  // DONE always lasts exactly one cycle, so decoding it gives the pulse directly.
  assign done     = (state_q == StDone);

endmodule
